// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: result select, sub-word load extraction; retire counter under MEM_WB_RETIRE_CNT_EN.
// Latency: one cycle from M-stage inputs to W-stage outputs.
// Backpressure: StallW holds every W register, FlushW (higher priority) drops the slot to a bubble.
module mem_wb_stage #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  StallW,
    input  logic                  FlushW,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [2:0]            LoadTypeM,
    input  logic [XLEN-1:0]       ALUOutM,
    input  logic [XLEN-1:0]       DATA_MEM,
    input  logic [XLEN-1:0]       PCPlus4M,
    input  logic [REG_ADDR_W-1:0] wb_addrM,
    output logic                  ValidW,
    output logic                  RegWriteW,
    output logic [XLEN-1:0]       ResultW,
    output logic [REG_ADDR_W-1:0] wb_addrW
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0]           RetireCount
`endif
);

    localparam int LANE_BITS = $clog2(XLEN / 8);

    logic [LANE_BITS-1:0]  byte_lane;
    logic [LANE_BITS-2:0]  half_lane;
    logic [7:0]            byte_val;
    logic [15:0]           half_val;
    logic [XLEN-1:0]       load_val;
    logic [XLEN-1:0]       result_d;
    logic                  regwrite_d;
    logic                  addr_ok;

    logic                  valid_q;
    logic                  regwrite_q;
    logic [XLEN-1:0]       result_q;
    logic [REG_ADDR_W-1:0] addr_q;

    // ALUOutM[0] plays no part in half-word lane selection.
    assign byte_lane = ALUOutM[LANE_BITS-1:0];
    assign half_lane = ALUOutM[LANE_BITS-1:1];

    always_comb begin
        byte_val = '0;
        half_val = '0;
        for (int i = 0; i < XLEN / 8; i++) begin
            if (byte_lane == i[LANE_BITS-1:0]) byte_val = DATA_MEM[8*i +: 8];
        end
        for (int j = 0; j < XLEN / 16; j++) begin
            if (half_lane == j[LANE_BITS-2:0]) half_val = DATA_MEM[16*j +: 16];
        end
    end

    always_comb begin
        load_val = DATA_MEM;
        case (LoadTypeM)
            3'b001:  load_val = {{(XLEN-8){byte_val[7]}}, byte_val};
            3'b010:  load_val = {{(XLEN-16){half_val[15]}}, half_val};
            3'b011:  load_val = {{(XLEN-8){1'b0}}, byte_val};
            3'b100:  load_val = {{(XLEN-16){1'b0}}, half_val};
            default: load_val = DATA_MEM;
        endcase
    end

    always_comb begin
        result_d = ALUOutM;
        case (ResultSrcM)
            2'b01:   result_d = load_val;
            2'b10:   result_d = PCPlus4M;
            default: result_d = ALUOutM;
        endcase
    end

    assign addr_ok    = (ZERO_REG_GUARD == 0) || (wb_addrM != '0);
    assign regwrite_d = RegWriteM & ValidM & addr_ok;

    // Flush clears only the qualifiers; data and address keep their last values.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            result_q   <= '0;
            addr_q     <= '0;
        end else if (FlushW) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (!StallW) begin
            valid_q    <= ValidM;
            regwrite_q <= regwrite_d;
            result_q   <= result_d;
            addr_q     <= wb_addrM;
        end
    end

    assign ValidW    = valid_q;
    assign RegWriteW = regwrite_q;
    assign ResultW   = result_q;
    assign wb_addrW  = addr_q;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            retire_q <= '0;
        end else if (!FlushW && !StallW && ValidM) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign RetireCount = retire_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: guarded and unguarded instances driven in parallel, checked against a spec-level model.
module tb_mem_wb_stage;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        StallW = 1'b0;
    logic        FlushW = 1'b0;
    logic        ValidM = 1'b0;
    logic        RegWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [2:0]  LoadTypeM = 3'b000;
    logic [31:0] ALUOutM = '0;
    logic [31:0] DATA_MEM = '0;
    logic [31:0] PCPlus4M = '0;
    logic [4:0]  wb_addrM = '0;

    logic        ValidW, RegWriteW, ValidW_ng, RegWriteW_ng;
    logic [31:0] ResultW, ResultW_ng;
    logic [4:0]  wb_addrW, wb_addrW_ng;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] RetireCount, RetireCount_ng;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 CLOCK = ~CLOCK;

    mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .ZERO_REG_GUARD(1)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .LoadTypeM(LoadTypeM), .ALUOutM(ALUOutM), .DATA_MEM(DATA_MEM),
        .PCPlus4M(PCPlus4M), .wb_addrM(wb_addrM), .ValidW(ValidW),
        .RegWriteW(RegWriteW), .ResultW(ResultW), .wb_addrW(wb_addrW)
`ifdef MEM_WB_RETIRE_CNT_EN
        , .RetireCount(RetireCount)
`endif
    );

    mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .ZERO_REG_GUARD(0)) dut_ng (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .LoadTypeM(LoadTypeM), .ALUOutM(ALUOutM), .DATA_MEM(DATA_MEM),
        .PCPlus4M(PCPlus4M), .wb_addrM(wb_addrM), .ValidW(ValidW_ng),
        .RegWriteW(RegWriteW_ng), .ResultW(ResultW_ng), .wb_addrW(wb_addrW_ng)
`ifdef MEM_WB_RETIRE_CNT_EN
        , .RetireCount(RetireCount_ng)
`endif
    );

    // Spec-level model: what the W stage must hold after each edge.
    logic        m_valid = 1'b0, m_rw = 1'b0, m_rw_ng = 1'b0;
    logic [31:0] m_res = '0, m_cnt = '0;
    logic [4:0]  m_addr = '0;

    function automatic logic [31:0] load_value(input logic [31:0] data, input logic [31:0] addr,
                                               input logic [2:0] lt);
        logic [31:0] b, h;
        b = (data >> (8 * (addr % 4))) & 32'hFF;
        h = (data >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (lt)
            3'd1:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd2:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] select_value();
        if (ResultSrcM == 2'd1) return load_value(DATA_MEM, ALUOutM, LoadTypeM);
        if (ResultSrcM == 2'd2) return PCPlus4M;
        return ALUOutM;
    endfunction

    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_rw_ng <= 1'b0;
            m_res <= '0; m_addr <= '0; m_cnt <= '0;
        end else if (FlushW) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_rw_ng <= 1'b0;
        end else if (!StallW) begin
            m_valid <= ValidM;
            m_rw    <= ValidM && RegWriteM && (wb_addrM != 5'd0);
            m_rw_ng <= ValidM && RegWriteM;
            m_res   <= select_value();
            m_addr  <= wb_addrM;
            if (ValidM) m_cnt <= m_cnt + 32'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK) begin
        if (chk_en) begin
            check("model ValidW",       {31'd0, ValidW},       {31'd0, m_valid});
            check("model RegWriteW",    {31'd0, RegWriteW},    {31'd0, m_rw});
            check("model ResultW",      ResultW,               m_res);
            check("model wb_addrW",     {27'd0, wb_addrW},     {27'd0, m_addr});
            check("model ng ValidW",    {31'd0, ValidW_ng},    {31'd0, m_valid});
            check("model ng RegWriteW", {31'd0, RegWriteW_ng}, {31'd0, m_rw_ng});
            check("model ng ResultW",   ResultW_ng,            m_res);
            check("model ng wb_addrW",  {27'd0, wb_addrW_ng},  {27'd0, m_addr});
`ifdef MEM_WB_RETIRE_CNT_EN
            check("model RetireCount",  RetireCount,           m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #3;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                         input logic [4:0] addr);
        ValidM = v; RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt;
        ALUOutM = alu; DATA_MEM = mem; PCPlus4M = pc; wb_addrM = addr;
    endtask

    task automatic expect_w(input string name, input logic v, input logic rw,
                            input logic [31:0] res, input logic [4:0] addr);
        check({name, " ValidW"},    {31'd0, ValidW},    {31'd0, v});
        check({name, " RegWriteW"}, {31'd0, RegWriteW}, {31'd0, rw});
        check({name, " ResultW"},   ResultW,            res);
        check({name, " wb_addrW"},  {27'd0, wb_addrW},  {27'd0, addr});
    endtask

    initial begin
        #1 RESET_N = 1'b0;
        chk_en = 1'b1;
        tick(); tick();
        expect_w("reset", 1'b0, 1'b0, 32'h0, 5'd0);
        RESET_N = 1'b1;

        // Result select
        drive(1, 1, 2'b00, 3'd0, 32'h00001234, 32'h0, 32'h00000040, 5'd7);
        tick(); expect_w("sel alu", 1'b1, 1'b1, 32'h00001234, 5'd7);
        ResultSrcM = 2'b10;
        tick(); expect_w("sel link", 1'b1, 1'b1, 32'h00000040, 5'd7);
        ResultSrcM = 2'b11;
        tick(); expect_w("sel 11", 1'b1, 1'b1, 32'h00001234, 5'd7);

        // Sub-word loads from 0x80FF7F01
        drive(1, 1, 2'b01, 3'd1, 32'h2, 32'h80FF7F01, 32'h0, 5'd3);
        tick(); check("lb lane2", ResultW, 32'hFFFFFFFF);
        LoadTypeM = 3'd3;
        tick(); check("lbu lane2", ResultW, 32'h000000FF);
        LoadTypeM = 3'd2;
        tick(); check("lh lane1", ResultW, 32'hFFFF80FF);
        ALUOutM = 32'h3;
        tick(); check("lh bit0 ignored", ResultW, 32'hFFFF80FF);
        LoadTypeM = 3'd4; ALUOutM = 32'h0;
        tick(); check("lhu lane0", ResultW, 32'h00007F01);
        LoadTypeM = 3'd1; ALUOutM = 32'h1;
        tick(); check("lb lane1", ResultW, 32'h0000007F);
        LoadTypeM = 3'd0;
        tick(); check("lw", ResultW, 32'h80FF7F01);
        LoadTypeM = 3'd7;
        tick(); check("load type 7", ResultW, 32'h80FF7F01);

        // Stall holds for three cycles while inputs change
        drive(1, 1, 2'b00, 3'd0, 32'hCAFE0001, 32'h0, 32'h0, 5'd9);
        tick(); expect_w("pre-stall", 1'b1, 1'b1, 32'hCAFE0001, 5'd9);
        StallW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1'b0, 2'b10, 3'd0, 32'h1000 + i, 32'h0, 32'h2000 + i, 5'(i + 20));
            tick(); expect_w("stall hold", 1'b1, 1'b1, 32'hCAFE0001, 5'd9);
        end
        FlushW = 1'b1;
        tick(); expect_w("flush over stall", 1'b0, 1'b0, 32'hCAFE0001, 5'd9);
        FlushW = 1'b0; StallW = 1'b0;

        // Zero-register guard and invalid slot
        drive(1, 1, 2'b00, 3'd0, 32'h55, 32'h0, 32'h0, 5'd0);
        tick();
        check("guard on", {31'd0, RegWriteW}, 32'd0);
        check("guard off", {31'd0, RegWriteW_ng}, 32'd1);
        drive(0, 1, 2'b00, 3'd0, 32'h66, 32'h0, 32'h0, 5'd4);
        tick(); expect_w("invalid slot", 1'b0, 1'b0, 32'h66, 5'd4);

        // Asynchronous reset between edges, while stalled
        drive(1, 1, 2'b00, 3'd0, 32'h77, 32'h0, 32'h0, 5'd5);
        tick(); StallW = 1'b1;
        RESET_N = 1'b0;
        #1 expect_w("async reset", 1'b0, 1'b0, 32'h0, 5'd0);
        tick(); StallW = 1'b0; RESET_N = 1'b1;

`ifdef MEM_WB_RETIRE_CNT_EN
        // Five retirements with one stalled and one flushed edge interleaved
        drive(1, 1, 2'b00, 3'd0, 32'h1, 32'h0, 32'h0, 5'd1);
        tick(); tick();
        StallW = 1'b1; tick(); StallW = 1'b0;
        tick();
        FlushW = 1'b1; tick(); FlushW = 1'b0;
        tick(); tick();
        ValidM = 1'b0; tick();
        check("retire count", RetireCount, 32'd5);
`endif

        drive(0, 0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick(); tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
